// File: rtl/int_ctrl_pkg.sv
// Shared constants for the AXI4-Lite interrupt controller: register word
// indices, CSR bit positions and source/ID widths.
package int_ctrl_pkg;

  localparam int C_NSRC   = 7;
  localparam int C_ID_W   = 3;
  localparam int C_PRIO_W = C_NSRC * C_ID_W;

  // Word indices decoded from addr[4:2]
  localparam logic [2:0] REG_CSR    = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_PRIO   = 3'd2;
  localparam logic [2:0] REG_SWTRIG = 3'd3;
  localparam logic [2:0] REG_PEND   = 3'd4;

  localparam int CSR_EN         = 1;
  localparam int CSR_ACK        = 2;
  localparam int CSR_CUR_ID_LSB = 8;
  localparam int CSR_ACTIVE     = 15;

  function automatic logic [31:0] csr_value(input logic en,
                                            input logic active,
                                            input logic [C_ID_W-1:0] cur_id);
    logic [31:0] v;
    v = '0;
    v[CSR_EN] = en;
    v[CSR_ACTIVE] = active;
    v[CSR_CUR_ID_LSB +: C_ID_W] = cur_id;
    return v;
  endfunction

endpackage

// File: rtl/int_prio_arb.sv
// Combinational priority scan: the lowest-numbered slot holding the ID of a
// pending, unmasked source wins.
module int_prio_arb
  import int_ctrl_pkg::*;
(
  input  logic [C_PRIO_W-1:0] prio,
  input  logic [C_NSRC-1:0]   pend,
  input  logic [C_NSRC-1:0]   mask,
  output logic                win_valid,
  output logic [C_ID_W-1:0]   win_id
);

  // Indexed directly by source ID; position 0 stands for an empty slot.
  logic [C_NSRC:0]   elig_by_id;
  logic [C_NSRC-1:0] slot_hit;

  assign elig_by_id = {pend & ~mask, 1'b0};

  for (genvar gi = 0; gi < C_NSRC; gi++) begin : g_slot
    assign slot_hit[gi] = elig_by_id[prio[gi*C_ID_W +: C_ID_W]];
  end

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int s = C_NSRC - 1; s >= 0; s--) begin
      if (slot_hit[s]) begin
        win_valid = 1'b1;
        win_id    = prio[s*C_ID_W +: C_ID_W];
      end
    end
  end

endmodule

// File: rtl/axi_slv_int_ctrl.sv
// AXI4-Lite slave interrupt controller: register file, edge detection of
// hardware/software triggers, priority delivery and acknowledge.
module axi_slv_int_ctrl #(
  parameter int C_ADDR_W = 5,
  parameter int C_NSRC   = 7
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [C_ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [C_ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic [C_NSRC-1:0]   irq_in,
  output logic                irq
);
  import int_ctrl_pkg::*;

  logic                wr_ready_reg;
  logic                bvalid_reg;
  logic                arready_reg;
  logic                rvalid_reg;
  logic [31:0]         rdata_reg;

  logic                en_reg;
  logic [C_NSRC-1:0]   mask_reg;
  logic [C_PRIO_W-1:0] prio_reg;
  logic [C_NSRC-1:0]   swtrig_reg;
  logic [C_NSRC-1:0]   pend_reg;
  logic [C_NSRC-1:0]   trig_q_reg;
  logic                active_reg;
  logic [C_ID_W-1:0]   cur_id_reg;

  logic                wr_fire;
  logic                rd_fire;
  logic [2:0]          wr_idx;
  logic [2:0]          rd_idx;
  logic                ack;
  logic [C_NSRC-1:0]   trig;
  logic [C_NSRC-1:0]   rise;
  logic [C_NSRC-1:0]   ack_clr;
  logic [C_NSRC-1:0]   pend_next;
  logic [31:0]         rd_val;
  logic                win_valid;
  logic [C_ID_W-1:0]   win_id;
  logic                unused_ok;

  assign wr_fire = wr_ready_reg & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire = arready_reg & s_axi_arvalid;
  assign wr_idx  = s_axi_awaddr[4:2];
  assign rd_idx  = s_axi_araddr[4:2];

  assign s_axi_awready = wr_ready_reg;
  assign s_axi_wready  = wr_ready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = 2'b00;

  assign irq = active_reg & en_reg;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                       s_axi_wdata[31:21], s_axi_wstrb[3]};

  // ACK only acts on an outstanding delivery; otherwise the write just sets EN.
  assign ack = wr_fire & (wr_idx == REG_CSR) & s_axi_wstrb[0]
             & s_axi_wdata[CSR_ACK] & active_reg;

  assign trig = irq_in | swtrig_reg;
  assign rise = trig & ~trig_q_reg;

  always_comb begin
    ack_clr = '0;
    if (ack) ack_clr[cur_id_reg - 3'd1] = 1'b1;
  end

  // A fresh edge on the acknowledged source keeps it pending.
  assign pend_next = (pend_reg & ~ack_clr) | rise;

  int_prio_arb u_arb (
    .prio      (prio_reg),
    .pend      (pend_reg),
    .mask      (mask_reg),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      REG_CSR:    rd_val = csr_value(en_reg, active_reg, cur_id_reg);
      REG_MASK:   rd_val[C_NSRC-1:0] = mask_reg;
      REG_PRIO:   rd_val[C_PRIO_W-1:0] = prio_reg;
      REG_SWTRIG: rd_val[C_NSRC-1:0] = swtrig_reg;
      REG_PEND:   rd_val[C_NSRC-1:0] = pend_reg;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ready_reg <= 1'b0;
      bvalid_reg   <= 1'b0;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      wr_ready_reg <= s_axi_awvalid & s_axi_wvalid & ~bvalid_reg & ~wr_ready_reg;
      if (wr_fire)           bvalid_reg <= 1'b1;
      else if (s_axi_bready) bvalid_reg <= 1'b0;

      arready_reg <= s_axi_arvalid & ~rvalid_reg & ~arready_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_val;
      end else if (s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_reg     <= 1'b0;
      mask_reg   <= '0;
      prio_reg   <= '0;
      swtrig_reg <= '0;
    end else if (wr_fire) begin
      case (wr_idx)
        REG_CSR:    if (s_axi_wstrb[0]) en_reg <= s_axi_wdata[CSR_EN];
        REG_MASK:   if (s_axi_wstrb[0]) mask_reg <= s_axi_wdata[C_NSRC-1:0];
        REG_PRIO: begin
          if (s_axi_wstrb[0]) prio_reg[7:0]   <= s_axi_wdata[7:0];
          if (s_axi_wstrb[1]) prio_reg[15:8]  <= s_axi_wdata[15:8];
          if (s_axi_wstrb[2]) prio_reg[20:16] <= s_axi_wdata[20:16];
        end
        REG_SWTRIG: if (s_axi_wstrb[0]) swtrig_reg <= s_axi_wdata[C_NSRC-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trig_q_reg <= '0;
      pend_reg   <= '0;
      active_reg <= 1'b0;
      cur_id_reg <= '0;
    end else begin
      trig_q_reg <= trig;
      pend_reg   <= pend_next;
      if (ack) begin
        active_reg <= 1'b0;
        cur_id_reg <= '0;
      end else if (!active_reg && en_reg && win_valid) begin
        active_reg <= 1'b1;
        cur_id_reg <= win_id;
      end
    end
  end

endmodule

// File: tb/tb_axi_slv_int_ctrl.sv
// Self-checking bench for axi_slv_int_ctrl: directed scenarios plus a
// randomized configuration run checked against a slot-scan reference model.
module tb_axi_slv_int_ctrl;

  localparam logic [4:0] A_CSR    = 5'h00;
  localparam logic [4:0] A_MASK   = 5'h04;
  localparam logic [4:0] A_PRIO   = 5'h08;
  localparam logic [4:0] A_SWTRIG = 5'h0C;
  localparam logic [4:0] A_PEND   = 5'h10;
  localparam logic [4:0] A_NONE   = 5'h14;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [6:0]  irq_in;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [6:0] m_pend;
  logic [6:0] m_mask;
  logic [2:0] m_prio [7];

  always #5 aclk = ~aclk;

  axi_slv_int_ctrl #(.C_ADDR_W(5), .C_NSRC(7)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .irq_in        (irq_in),
    .irq           (irq)
  );

  // Reference: first slot naming a pending, unmasked source.
  function automatic logic [2:0] model_winner();
    for (int s = 0; s < 7; s++) begin
      if (m_prio[s] != 3'd0) begin
        if (m_pend[m_prio[s] - 3'd1] && !m_mask[m_prio[s] - 3'd1]) return m_prio[s];
      end
    end
    return 3'd0;
  endfunction

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; irq_in = '0;
    bready = 1'b1; rready = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    m_pend = '0;
    m_mask = '0;
    for (int s = 0; s < 7; s++) m_prio[s] = 3'd0;
  endtask

  // Returns at the falling edge just after the write handshake.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    @(negedge aclk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    while (awready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      failures++;
      $display("FAIL write_handshake addr=%h awready=%b wready=%b required 1", addr, awready, wready);
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    $display("write addr=%h data=%h strb=%h", addr, data, strb);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    n = 0;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    @(negedge aclk);
    while (arready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      failures++;
      $display("FAIL read_handshake addr=%h rvalid=%b required 1", addr, rvalid);
    end
    data = rdata;
    $display("read  addr=%h data=%h", addr, data);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required 000000", {awready, wready, bvalid, arready, rvalid, irq});
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int r = 0; r < 5; r++) begin
      axi_read(5'(r * 4), rd);
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h required 00000000", r, rd);
      end
    end
    axi_write(A_MASK, 32'h2A, 4'hF);
    axi_read(A_MASK, rd);
    checks++;
    if (rd !== 32'h2A) begin failures++; $display("FAIL mask_rw got=%h required 0000002a", rd); end
    axi_write(A_MASK, 32'h7F, 4'h0);
    axi_read(A_MASK, rd);
    checks++;
    if (rd !== 32'h2A) begin failures++; $display("FAIL mask_nostrb got=%h required 0000002a", rd); end
  endtask

  task automatic test_priority_ack();
    logic [31:0] rd;
    logic seen;
    do_reset();
    axi_write(A_MASK, 32'h01, 4'hF);
    axi_write(A_PRIO, 32'd92, 4'hF);
    axi_write(A_CSR, 32'h2, 4'hF);
    axi_write(A_SWTRIG, 32'd13, 4'hF);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_edge_cycle got=%b required 0", irq); end
    @(negedge aclk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_pend_cycle got=%b required 0", irq); end
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_latency got=%b required 1", irq); end
    axi_write(A_SWTRIG, 32'd0, 4'hF);
    axi_read(A_PEND, rd);
    checks++;
    if (rd !== 32'h0D) begin failures++; $display("FAIL pend_0d got=%h required 0000000d", rd); end
    axi_read(A_CSR, rd);
    checks++;
    if (rd !== 32'h8402) begin failures++; $display("FAIL csr_id4 got=%h required 00008402", rd); end

    axi_write(A_CSR, 32'd14, 4'hF);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL ack_low got=%b required 0", irq); end
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL ack_next got=%b required 1", irq); end
    axi_read(A_CSR, rd);
    checks++;
    if (rd !== 32'h8302) begin failures++; $display("FAIL csr_id3 got=%h required 00008302", rd); end
    axi_read(A_PEND, rd);
    checks++;
    if (rd !== 32'h05) begin failures++; $display("FAIL pend_05 got=%h required 00000005", rd); end

    axi_write(A_CSR, 32'd14, 4'hF);
    seen = irq;
    repeat (4) begin
      @(negedge aclk);
      seen = seen | irq;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL masked_stays_low got=%b required 0", seen); end
    axi_write(A_CSR, 32'd6, 4'hF);
    axi_read(A_PEND, rd);
    checks++;
    if (rd !== 32'h01) begin failures++; $display("FAIL pend_01 got=%h required 00000001", rd); end
    axi_read(A_CSR, rd);
    checks++;
    if (rd !== 32'h0002) begin failures++; $display("FAIL csr_idle got=%h required 00000002", rd); end
  endtask

  task automatic test_en_gate();
    logic [31:0] rd;
    do_reset();
    @(negedge aclk);
    irq_in = 7'h02;
    @(negedge aclk);
    irq_in = 7'h00;
    repeat (3) @(negedge aclk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL en0_irq got=%b required 0", irq); end
    axi_read(A_PEND, rd);
    checks++;
    if (rd !== 32'h02) begin failures++; $display("FAIL en0_pend got=%h required 00000002", rd); end
    axi_write(A_PRIO, 32'h2, 4'hF);
    axi_write(A_CSR, 32'h2, 4'hF);
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL en1_irq got=%b required 1", irq); end
    axi_read(A_CSR, rd);
    checks++;
    if (rd !== 32'h8202) begin failures++; $display("FAIL en1_csr got=%h required 00008202", rd); end
    axi_write(A_MASK, 32'h02, 4'hF);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL mask_keeps got=%b required 1", irq); end
    axi_write(A_CSR, 32'h0, 4'hF);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL en_off_irq got=%b required 0", irq); end
    axi_read(A_CSR, rd);
    checks++;
    if (rd !== 32'h8200) begin failures++; $display("FAIL en_off_csr got=%h required 00008200", rd); end
    axi_write(A_CSR, 32'h2, 4'hF);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL en_on_irq got=%b required 1", irq); end
  endtask

  task automatic test_absent();
    logic [31:0] rd;
    logic seen;
    do_reset();
    axi_write(A_CSR, 32'h2, 4'hF);
    axi_write(A_SWTRIG, 32'h40, 4'hF);
    seen = irq;
    axi_write(A_SWTRIG, 32'h0, 4'hF);
    repeat (8) begin
      @(negedge aclk);
      seen = seen | irq;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL absent_irq got=%b required 0", seen); end
    axi_read(A_PEND, rd);
    checks++;
    if (rd !== 32'h40) begin failures++; $display("FAIL absent_pend got=%h required 00000040", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int n;
    do_reset();
    bready = 1'b0;
    @(negedge aclk);
    awaddr = A_MASK; wdata = 32'h15; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
        failures++;
        $display("FAIL b_hold c=%0d bvalid=%b bresp=%b awready=%b required 1 00 0", c, bvalid, bresp, awready);
      end
    end
    bready = 1'b1;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0) begin failures++; $display("FAIL b_release got=%b required 0", bvalid); end

    rready = 1'b0;
    @(negedge aclk);
    araddr = A_MASK; arvalid = 1'b1;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h15 || rresp !== 2'b00) begin
        failures++;
        $display("FAIL r_hold c=%0d rvalid=%b rdata=%h rresp=%b required 1 00000015 00", c, rvalid, rdata, rresp);
      end
    end
    rready = 1'b1;
    @(negedge aclk);
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL r_release got=%b required 0", rvalid); end

    axi_write(A_NONE, 32'hFFFF_FFFF, 4'hF);
    axi_read(A_NONE, rd);
    checks++;
    if (rd !== 32'h0 || rresp !== 2'b00) begin
      failures++;
      $display("FAIL unmapped got=%h resp=%b required 00000000 00", rd, rresp);
    end
    axi_read(A_MASK, rd);
    checks++;
    if (rd !== 32'h15) begin failures++; $display("FAIL unmapped_wr got=%h required 00000015", rd); end
    axi_write(A_PRIO, 32'h00AB_CDEF, 4'h2);
    axi_read(A_PRIO, rd);
    checks++;
    if (rd !== 32'h0000_CD00) begin failures++; $display("FAIL prio_strb got=%h required 0000cd00", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [20:0] pv;
    logic [6:0]  pat;
    logic [2:0]  w;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      axi_write(A_CSR, 32'h0, 4'hF);
      m_mask = 7'($urandom_range(0, 127));
      axi_write(A_MASK, {25'b0, m_mask}, 4'hF);
      for (int s = 0; s < 7; s++) begin
        m_prio[s] = 3'($urandom_range(0, 7));
        pv[s*3 +: 3] = m_prio[s];
      end
      axi_write(A_PRIO, {11'b0, pv}, 4'hF);
      pat = 7'($urandom_range(1, 127));
      axi_write(A_SWTRIG, {25'b0, pat}, 4'hF);
      axi_write(A_SWTRIG, 32'h0, 4'hF);
      m_pend = m_pend | pat;
      axi_write(A_CSR, 32'h2, 4'hF);
      repeat (3) @(negedge aclk);
      for (int k = 0; k < 8; k++) begin
        w = model_winner();
        axi_read(A_PEND, rd);
        checks++;
        if (rd !== {25'b0, m_pend}) begin
          failures++;
          $display("FAIL rnd_pend it=%0d got=%h required %h", it, rd, {25'b0, m_pend});
        end
        checks++;
        if (irq !== (w != 3'd0)) begin
          failures++;
          $display("FAIL rnd_irq it=%0d got=%b required %b", it, irq, (w != 3'd0));
        end
        if (w == 3'd0) break;
        axi_read(A_CSR, rd);
        checks++;
        if (rd[10:8] !== w) begin
          failures++;
          $display("FAIL rnd_cur_id it=%0d got=%0d required %0d", it, rd[10:8], w);
        end
        axi_write(A_CSR, 32'h6, 4'hF);
        m_pend[w - 3'd1] = 1'b0;
        repeat (2) @(negedge aclk);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    irq_in = '0;
    m_pend = '0; m_mask = '0;
    for (int s = 0; s < 7; s++) m_prio[s] = 3'd0;
    test_reset();
    test_priority_ack();
    test_en_gate();
    test_absent();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
